rv32im_dmem: RTL and testbench

Data-memory responder on the far side of the rv32im LSU memory port. It accepts one load or store request at a time from the LSU/core. It applies byte-lane write enables to an internal word array and returns the full 32-bit read word; the LSU extracts lanes and sign-extends. It has a programmable wait-state count and a registered response with a valid/ready handshake, so pipeline stall logic can be exercised against a realistic memory.

---
 rtl/rv32im_dmem.sv | 144 ++++++++++++++
 tb/tb_rv32im_dmem.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32im_dmem.sv
// rtl/rv32im_dmem.sv - data-memory responder for the rv32im LSU memory port
//
// Ports:
//   clk_i, rst_i              clock; synchronous active-high reset
//   req_valid_i, req_ready_o  request handshake (one transaction at a time)
//   req_we_i                  1 = store, 0 = load
//   req_be_i                  byte-lane enables, bit n selects bits [8n+7:8n]
//   req_addr_i                byte address, bits [1:0] ignored
//   req_wdata_i               lane-positioned store data
//   rsp_valid_o, rsp_ready_i  response handshake
//   rsp_rdata_o               full read word; 0 for stores and errors
//   rsp_err_o                 illegal address or byte-enable pattern
module rv32im_dmem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [30:0] DEPTH_31 = 31'(DEPTH_WORDS);
  // The counter holds the number of WAIT cycles still to spend after this one.
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;

  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait states the access happens on the accept edge itself,
  // so the access path takes the live request while in IDLE and the
  // latched copy otherwise.
  logic        from_idle;
  logic        acc_we;
  logic [3:0]  acc_be;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [29:0] word_off;
  logic [IDX_W-1:0] acc_idx;
  logic        in_range;
  logic        be_legal;
  logic        legal;
  logic        enter_resp;
  logic        do_write;

  assign from_idle = (state == ST_IDLE);
  assign acc_we    = from_idle ? req_we_i    : we_q;
  assign acc_be    = from_idle ? req_be_i    : be_q;
  assign acc_addr  = from_idle ? req_addr_i  : addr_q;
  assign acc_wdata = from_idle ? req_wdata_i : wdata_q;

  // BASE_ADDR is word aligned, so comparing full byte addresses is enough
  // to reject anything below the window, including wrapped offsets.
  assign word_off = acc_addr[31:2] - BASE_ADDR[31:2];
  assign in_range = (acc_addr >= BASE_ADDR) && ({1'b0, word_off} < DEPTH_31);
  assign acc_idx  = word_off[IDX_W-1:0];

  always_comb begin
    be_legal = 1'b0;
    case (acc_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  end

  assign legal = in_range && be_legal;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (req_valid_i) state_n = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 4'd0) state_n = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign enter_resp = !rst_i && (state != ST_RESP) && (state_n == ST_RESP);
  assign do_write   = enter_resp && legal && acc_we;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (from_idle && req_valid_i) begin
        we_q    <= req_we_i;
        be_q    <= req_be_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        cnt     <= CNT_LOAD;
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        err_q   <= !legal;
        rdata_q <= (legal && !acc_we) ? mem[acc_idx] : 32'd0;
      end
    end
  end

  // Memory contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (do_write && acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
    end
  end

  assign req_ready_o = from_idle && !rst_i;
  assign rsp_valid_o = (state == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_rv32im_dmem.sv
// tb/tb_rv32im_dmem.sv - self-checking bench for rv32im_dmem
module tb_rv32im_dmem;

  localparam int NI = 2;

  // instance 0: 1024 words at 0, no wait states; instance 1: 16 words at 0x1000, 3 wait states
  function automatic int dep_of(input int i);
    return (i == 0) ? 1024 : 16;
  endfunction
  function automatic longint base_of(input int i);
    return (i == 0) ? 64'h0 : 64'h1000;
  endfunction
  function automatic int wc_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  logic        clk = 1'b0;
  logic        rst       [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [3:0]  req_be    [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];

  always #5 clk = ~clk;

  rv32im_dmem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) u0 (
    .clk_i(clk), .rst_i(rst[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_be_i(req_be[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
  );

  rv32im_dmem #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(3)) u1 (
    .clk_i(clk), .rst_i(rst[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_be_i(req_be[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL u%0d %s: got 0x%0h expected 0x%0h", i, nm, act, exp);
  endfunction

  // Transaction-level model: expected handshake levels and response per instance.
  bit          live   [NI];
  bit          pend   [NI];
  bit          rout   [NI];
  int          remain [NI];
  bit          q_we   [NI];
  logic [3:0]  q_be   [NI];
  logic [31:0] q_addr [NI];
  logic [31:0] q_wd   [NI];
  logic [31:0] erd    [NI];
  bit          eerr   [NI];
  bit          eknown [NI];
  logic [31:0] mm     [NI][1024];
  bit   [3:0]  mk     [NI][1024];

  function automatic void mdl_access(input int i, input bit we, input logic [3:0] be,
                                     input logic [31:0] addr, input logic [31:0] wd);
    longint a = {32'h0, addr};
    longint b = base_of(i);
    int     idx;
    bit     ok;
    ok = (a >= b) && (((a - b) / 4) < dep_of(i)) &&
         (be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
    eknown[i] = 1'b1;
    erd[i]    = 32'h0;
    eerr[i]   = !ok;
    if (ok) begin
      idx = int'((a - b) / 4);
      if (we) begin
        for (int k = 0; k < 4; k++) begin
          if (be[k]) begin
            mm[i][idx][8*k +: 8] = wd[8*k +: 8];
            mk[i][idx][k] = 1'b1;
          end
        end
      end else begin
        erd[i]    = mm[i][idx];
        eknown[i] = (mk[i][idx] == 4'hF);
      end
    end
  endfunction

  // Check outputs at each falling edge, then advance the model across the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (live[i]) begin
          chk("req_ready", i, 32'(req_ready[i]), 32'(!rst[i] && !pend[i] && !rout[i]));
          chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(rout[i]));
          if (rout[i]) begin
            chk("rsp_err", i, 32'(rsp_err[i]), 32'(eerr[i]));
            if (eknown[i]) chk("rsp_rdata", i, rsp_rdata[i], erd[i]);
          end
        end
        if (rst[i]) begin
          live[i] = 1'b1;
          pend[i] = 1'b0;
          rout[i] = 1'b0;
        end else if (!live[i]) begin
          pend[i] = 1'b0;
        end else if (rout[i]) begin
          if (rsp_ready[i]) rout[i] = 1'b0;
        end else if (pend[i]) begin
          if (remain[i] == 1) begin
            mdl_access(i, q_we[i], q_be[i], q_addr[i], q_wd[i]);
            pend[i] = 1'b0;
            rout[i] = 1'b1;
          end else begin
            remain[i]--;
          end
        end else if (req_valid[i]) begin
          if (wc_of(i) == 0) begin
            mdl_access(i, req_we[i], req_be[i], req_addr[i], req_wdata[i]);
            rout[i] = 1'b1;
          end else begin
            q_we[i]   = req_we[i];
            q_be[i]   = req_be[i];
            q_addr[i] = req_addr[i];
            q_wd[i]   = req_wdata[i];
            pend[i]   = 1'b1;
            remain[i] = wc_of(i);
          end
        end
      end
    end
  end

  task automatic issue(input int i, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    bit rdy;
    bit ok = 1'b0;
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_be[i]    = be;
    req_addr[i]  = addr;
    req_wdata[i] = wd;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      rdy = req_ready[i];
      @(posedge clk); #1;
      if (rdy) ok = 1'b1;
    end
    chk("accept", i, 32'(ok), 32'd1);
    // junk on the bus after accept must not be sampled
    req_valid[i] = 1'b0;
    req_we[i]    = 1'($urandom);
    req_be[i]    = 4'($urandom);
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
  endtask

  task automatic complete(input int i, input int stall, output logic [31:0] rd,
                          output logic er, output int lat);
    bit seen = 1'b0;
    bit done = 1'b0;
    int held = 0;
    rd  = 32'h0;
    er  = 1'b0;
    lat = 0;
    rsp_ready[i] = (stall == 0);
    for (int c = 1; c <= 64 && !done; c++) begin
      @(negedge clk);
      if (rsp_valid[i]) begin
        if (!seen) begin
          seen = 1'b1;
          lat  = c;
          rd   = rsp_rdata[i];
          er   = rsp_err[i];
        end
        if (rsp_ready[i]) done = 1'b1;
        else held++;
      end
      @(posedge clk); #1;
      if (seen && held >= stall) rsp_ready[i] = 1'b1;
    end
    rsp_ready[i] = 1'b0;
    chk("rsp_done", i, 32'(done), 32'd1);
  endtask

  task automatic xact(input int i, input bit we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wd, input int stall, output logic [31:0] rd,
                      output logic er, output int lat);
    issue(i, we, be, addr, wd);
    complete(i, stall, rd, er, lat);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    logic [3:0] legal_be [7];
    logic [3:0] be;
    logic [31:0] addr;
    int i;
    int g;
    legal_be = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_be[k] = 4'h0;
      req_addr[k] = 32'h0; req_wdata[k] = 32'h0; rsp_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("reset req_ready", k, 32'(req_ready[k]), 32'd0);
      chk("reset rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
      chk("reset rsp_err", k, 32'(rsp_err[k]), 32'd0);
      chk("reset rsp_rdata", k, rsp_rdata[k], 32'h0);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("post-reset req_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("post-reset req_ready", 1, 32'(req_ready[1]), 32'd1);
    @(posedge clk); #1;

    // zero wait states: full-word store then load
    xact(0, 1, 4'hF, 32'h10, 32'h000CF5BD, 0, rd, er, lat);
    chk("st rdata", 0, rd, 32'h0); chk("st err", 0, 32'(er), 0); chk("st latency", 0, lat, 1);
    xact(0, 0, 4'hF, 32'h10, 32'h0, 1, rd, er, lat);
    chk("ld 0x10", 0, rd, 32'h000CF5BD); chk("ld err", 0, 32'(er), 0); chk("ld latency", 0, lat, 1);

    // byte and half-word merges
    xact(0, 1, 4'hF, 32'h20, 32'hFFFFFFFF, 0, rd, er, lat);
    xact(0, 1, 4'b0010, 32'h20, 32'h0000AB00, 0, rd, er, lat);
    xact(0, 1, 4'b1100, 32'h22, 32'h12340000, 2, rd, er, lat);
    xact(0, 0, 4'b0001, 32'h20, 32'h0, 0, rd, er, lat);
    chk("merged 0x20", 0, rd, 32'h1234ABFF);

    // illegal requests
    xact(0, 1, 4'b0101, 32'h20, 32'h0, 0, rd, er, lat);
    chk("be0101 err", 0, 32'(er), 1); chk("be0101 rdata", 0, rd, 32'h0);
    xact(0, 1, 4'b0000, 32'h20, 32'h0, 0, rd, er, lat);
    chk("be0000 err", 0, 32'(er), 1);
    xact(0, 0, 4'b0101, 32'h20, 32'h0, 0, rd, er, lat);
    chk("ld be0101 err", 0, 32'(er), 1); chk("ld be0101 rdata", 0, rd, 32'h0);
    xact(0, 1, 4'hF, 32'h0, 32'h01020304, 0, rd, er, lat);
    xact(0, 1, 4'hF, 32'h1000, 32'hFFFFFFFF, 0, rd, er, lat);
    chk("oor err", 0, 32'(er), 1); chk("oor rdata", 0, rd, 32'h0);
    xact(0, 0, 4'hF, 32'h0, 32'h0, 0, rd, er, lat);
    chk("word0 intact", 0, rd, 32'h01020304);
    xact(0, 0, 4'hF, 32'h20, 32'h0, 0, rd, er, lat);
    chk("0x20 intact", 0, rd, 32'h1234ABFF);

    // three wait states, long response stall
    xact(1, 1, 4'hF, 32'h1004, 32'hCAFEF00D, 0, rd, er, lat);
    chk("w3 st latency", 1, lat, 4);
    xact(1, 0, 4'hF, 32'h1004, 32'h0, 5, rd, er, lat);
    chk("w3 ld 0x1004", 1, rd, 32'hCAFEF00D); chk("w3 ld latency", 1, lat, 4);
    xact(1, 1, 4'hF, 32'h0FFC, 32'h0, 0, rd, er, lat);
    chk("below base err", 1, 32'(er), 1);
    xact(1, 0, 4'hF, 32'h1040, 32'h0, 0, rd, er, lat);
    chk("above top err", 1, 32'(er), 1); chk("above top rdata", 1, rd, 32'h0);

    // reset while a store waits: the store must not land
    xact(1, 1, 4'hF, 32'h1030, 32'hDEADBEEF, 0, rd, er, lat);
    issue(1, 1, 4'hF, 32'h1030, 32'h11111111);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("after rst req_ready", 1, 32'(req_ready[1]), 32'd1);
    chk("after rst rsp_valid", 1, 32'(rsp_valid[1]), 32'd0);
    @(posedge clk); #1;
    xact(1, 0, 4'hF, 32'h1030, 32'h0, 0, rd, er, lat);
    chk("discarded store", 1, rd, 32'hDEADBEEF);

    // random traffic against the model
    for (int w = 0; w < 16; w++) begin
      xact(0, 1, 4'hF, 32'(w * 4), $urandom, 0, rd, er, lat);
      xact(1, 1, 4'hF, 32'h1000 + 32'(w * 4), $urandom, 0, rd, er, lat);
    end
    for (int n = 0; n < 1000; n++) begin
      i  = n % 2;
      be = ($urandom_range(0, 9) < 8) ? legal_be[$urandom_range(0, 6)] : 4'($urandom);
      case ($urandom_range(0, 19))
        0:       addr = 32'(base_of(i)) - 32'd4;
        1:       addr = 32'(base_of(i)) + 32'(dep_of(i) * 4) + 32'($urandom_range(0, 64));
        default: addr = 32'(base_of(i)) + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      endcase
      xact(i, 1'($urandom_range(0, 1)), be, addr, $urandom, $urandom_range(0, 3), rd, er, lat);
      chk("rand latency", i, lat, wc_of(i) + 1);
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
